// File: rtl/lab1_sweep_pkg.sv
// rtl/lab1_sweep_pkg.sv - shared types and constants for the Lab 1 truth-table sweeper
package lab1_sweep_pkg;

  localparam int N_VEC = 16;
  localparam int VEC_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/lab1_dwell_counter.sv
// rtl/lab1_dwell_counter.sv - per-vector dwell counter with sample and end strobes
module lab1_dwell_counter #(
  parameter int DWELL     = 100,
  parameter int SAMPLE_AT = 99
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_sample,
  output logic at_end
);

  localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_sample = (cnt_q == CNT_W'(SAMPLE_AT));
  assign at_end    = (cnt_q == CNT_W'(DWELL - 1));

  // Next count: clear wins, then wrap at the last dwell cycle so the next vector starts at 0
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lab1_truth_sweeper.sv
// rtl/lab1_truth_sweeper.sv - sweeps {A,B,C,D} 0..15 and captures F; comparator under LAB1_SWEEP_COMPARE_EN
module lab1_truth_sweeper
  import lab1_sweep_pkg::*;
#(
  parameter int DWELL     = 100,
  parameter int SAMPLE_AT = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             f_in,
  input  logic [N_VEC-1:0] expected,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic [VEC_W-1:0] vec_idx,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_out,
  output logic             pass
);

  sweep_state_e     state_q;
  logic [VEC_W-1:0] vec_q;
  logic [N_VEC-1:0] table_q;
  logic [N_VEC-1:0] table_d;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             start_ok;
  logic             at_sample;
  logic             at_end;
  logic             cmp_match;

  // start is only honoured outside DRIVE
  assign start_ok = start && (state_q != DRIVE);

  lab1_dwell_counter #(
    .DWELL     (DWELL),
    .SAMPLE_AT (SAMPLE_AT)
  ) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q != DRIVE),
    .en        (state_q == DRIVE),
    .at_sample (at_sample),
    .at_end    (at_end)
  );

  // Next table: cleared on an accepted start, one bit written on the sample cycle
  always_comb begin
    table_d = table_q;
    if (start_ok) begin
      table_d = '0;
    end else if ((state_q == DRIVE) && at_sample) begin
      table_d[vec_q] = f_in;
    end
  end

`ifdef LAB1_SWEEP_COMPARE_EN
  // Compare against the next table so the final sample is included when done rises
  assign cmp_match = (table_d == expected);
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign cmp_match       = 1'b0;
`endif

  // Sweep FSM with registered vector, status and pass outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      table_q <= table_d;
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_q <= DRIVE;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (state_q == DONE) begin
            pass_q <= cmp_match;
          end
        end
        DRIVE: begin
          if (at_end) begin
            if (vec_q == VEC_W'(N_VEC - 1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= cmp_match;
            end else begin
              vec_q <= vec_q + VEC_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          vec_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A         = vec_q[3];
  assign B         = vec_q[2];
  assign C         = vec_q[1];
  assign D         = vec_q[0];
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_lab1_truth_sweeper.sv
// tb/tb_lab1_truth_sweeper.sv - directed bench for lab1_truth_sweeper with DWELL=4, SAMPLE_AT=3
module tb_lab1_truth_sweeper;

`ifdef LAB1_SWEEP_COMPARE_EN
  localparam logic CMP = 1'b1;
`else
  localparam logic CMP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        f_in;
  logic [15:0] expected;
  logic        A, B, C, D;
  logic [3:0]  vec_idx;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        pass;

  logic        fmode;
  logic        f_tog;
  int          n_checks;
  int          n_fails;
  int          k;

  lab1_truth_sweeper #(
    .DWELL     (4),
    .SAMPLE_AT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .f_in      (f_in),
    .expected  (expected),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done),
    .table_out (table_out),
    .pass      (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (fmode) f_in = f_tog;
    else       f_in = A ^ B ^ C ^ D;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_abcd"}, {28'd0, A, B, C, D}, 32'd0);
    check({tag, "_vec"},  {28'd0, vec_idx}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_tbl"},  {16'd0, table_out}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
  endtask

  // Called at a negedge; issues start and runs until done or a cycle budget expires
  task automatic sweep(input string tag, input bit mid_pulse);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_go_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_go_vec"},  {28'd0, vec_idx}, 32'd0);
    check({tag, "_go_tbl"},  {16'd0, table_out}, 32'd0);
    check({tag, "_go_done"}, {31'd0, done}, 32'd0);
    k = 0;
    while (!done && k < 200) begin
      if (fmode) f_tog = (((k + 1) % 4) == 0) ? (A & B & C & D) : ~f_tog;
      start = mid_pulse && (vec_idx == 4'd3);
      @(posedge clk);
      @(negedge clk);
      k++;
      if (!fmode && k == 8) begin
        check({tag, "_mid_tbl"}, {16'd0, table_out}, 32'h0002);
        check({tag, "_mid_vec"}, {28'd0, vec_idx}, 32'd2);
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, k, 32'd64);
    check({tag, "_end_abcd"}, {28'd0, A, B, C, D}, 32'hF);
    check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    start    = 1'b0;
    fmode    = 1'b0;
    f_tog    = 1'b0;
    expected = 16'h6996;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check_reset_values("idle");

    // XOR function, matching expected word
    sweep("xor_ok", 1'b0);
    check("xor_ok_tbl",  {16'd0, table_out}, 32'h6996);
    check("xor_ok_pass", {31'd0, pass}, {31'd0, CMP});

    // Expected changed while in DONE is reflected one cycle later
    expected = 16'h6997;
    @(posedge clk);
    @(negedge clk);
    check("done_exp_chg_pass", {31'd0, pass}, 32'd0);
    check("done_hold_tbl", {16'd0, table_out}, 32'h6996);

    // Restart from DONE with a mismatching expected word
    sweep("xor_bad", 1'b0);
    check("xor_bad_tbl",  {16'd0, table_out}, 32'h6996);
    check("xor_bad_pass", {31'd0, pass}, 32'd0);

    // Reset during vector 7
    expected = 16'h6996;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (vec_idx != 4'd7 && k < 100) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("rst_mid_reach_v7", {28'd0, vec_idx}, 32'd7);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_values("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_after");
    sweep("post_rst", 1'b0);
    check("post_rst_tbl",  {16'd0, table_out}, 32'h6996);
    check("post_rst_pass", {31'd0, pass}, {31'd0, CMP});

    // Start during DRIVE at vector 3 is ignored
    sweep("ign_start", 1'b1);
    check("ign_start_tbl", {16'd0, table_out}, 32'h6996);

    // f_in toggling away from sample edges, AND function on them
    fmode    = 1'b1;
    expected = 16'h8000;
    sweep("toggle", 1'b0);
    check("toggle_tbl",  {16'd0, table_out}, 32'h8000);
    check("toggle_pass", {31'd0, pass}, {31'd0, CMP});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lab1_truth_sweeper.md
# lab1_truth_sweeper

Synthesizable stimulus-and-capture stage placed directly upstream of the Lab 1 combinational function block (F = f(A,B,C,D)). On `start` it walks the 4-bit input vector {A,B,C,D} through 0000→1111, holding each for a fixed dwell, and samples F once per vector. It assembles the 16-entry truth table. With the compare feature compiled in, it also checks the table against an expected word.

## Interface
- `DWELL`, default 100: clock cycles each vector is held; legal range 2..65535.
- `SAMPLE_AT`, default 99: dwell-cycle index at which F is sampled; must satisfy 1 ≤ SAMPLE_AT ≤ DWELL-1.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin sweep; sampled only in IDLE or DONE.
- `f_in` in 1: F output of the downstream function block.
- `expected` in 16: expected truth table; bit i is F for vector i.
- `A`, `B`, `C`, `D` out 1 each: drive vector; {A,B,C,D} = current index, A = MSB.
- `vec_idx` out 4: current vector index.
- `busy` out 1: high in DRIVE.
- `done` out 1: high in DONE; held until the next `start`.
- `table_out` out 16: captured truth table; bit i = F sampled for vector i.
- `pass` out 1: table_out == expected (compare build only).

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE: vector 0000; dwell counter 0; `start`=1 → DRIVE next cycle, and table_out is cleared on the same edge.
- DRIVE: dwell counter counts 0..DWELL-1. At count == SAMPLE_AT, f_in is written into table_out[vec_idx]. At count == DWELL-1:
  - if vec_idx < 15: vec_idx increments and the counter returns to 0;
  - if vec_idx == 15: go to DONE, and vec_idx stays at 15.
- DONE: done=1; vector held at 1111; table_out frozen. `start`=1 → DRIVE with vec_idx=0, counter=0, table_out cleared, done=0.
- `start` in DRIVE is ignored. No abort input exists; only `rst` aborts.
- f_in changes outside the sample cycle have no effect.
- Reset values of all outputs: A=B=C=D=0, vec_idx=0, busy=0, done=0, table_out=0, pass=0. State is IDLE.
- Reset mid-sweep: immediate return to reset values. The partial table is discarded.

## Timing
- Edge n samples start=1 in IDLE; edge n+1 is the first DRIVE cycle, with vector 0000 and counter 0.
- Vector i is valid from cycle n+1+i·DWELL for exactly DWELL cycles.
- Sample for vector i happens on edge n+1+i·DWELL+SAMPLE_AT. The written bit is visible on table_out the following cycle.
- Total sweep is 16·DWELL cycles. done rises on the cycle after the last dwell cycle of vector 15.
- pass is registered. It updates in the same cycle done rises, and then every cycle while in DONE, so a changed `expected` is reflected one cycle later.
- Outputs A–D are registered and glitch-free. The downstream combinational block settles within one cycle, so SAMPLE_AT ≥ 1 is sufficient.

## Configuration
- `LAB1_SWEEP_COMPARE_EN` defined:
  - the comparator is present;
  - pass = (table_out == expected), registered, and valid only while done=1;
  - pass is forced to 0 otherwise.
- Not defined:
  - no comparator logic;
  - pass tied to 0;
  - `expected` is left unconnected internally (the port remains for a stable interface).

## Structure
- Package `lab1_sweep_pkg`:
  - state enum {IDLE, DRIVE, DONE};
  - constant N_VEC=16;
  - constant VEC_W=4.
- Sub-module `lab1_dwell_counter`: parameterized by DWELL; inputs clr/en; outputs `at_sample` (count==SAMPLE_AT) and `at_end` (count==DWELL-1).
- The top level holds the FSM, the vector register and the table register.

## Test plan
- Reset, then idle 50 cycles → all outputs 0, busy=0, done=0.
- DWELL=4, SAMPLE_AT=3; f_in modeled as F=A^B^C^D; expected=16'h6996; start pulse → done after 64+1 cycles, table_out=16'h6996, pass=1 (compare build).
- Same sweep with expected=16'h6997 → table_out=16'h6996, pass=0; with the macro undefined, pass=0 in both runs.
- Assert rst during vector 7 → outputs return to reset values immediately. A subsequent start produces a full, correct table.
- Pulse start again during DRIVE at vector 3 → ignored; sweep completes at the original time. Start in DONE → table_out cleared to 0 the next cycle, done=0, vector 0000.
- Toggle f_in every cycle except at sample edges, with F=A&B&C&D at sample edges → table_out=16'h8000.
